// File: rtl/interrupt_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : interrupt_ctrl_if
// Description : Signal bundle between the interrupt/trap sequencer and its
//               surroundings (CSR file, pipeline control, fetch stage).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface interrupt_ctrl_if;
  // Raw interrupt sources and CSR qualifiers
  logic        sensor_irq_raw;
  logic        wdt_irq_raw;
  logic        MIE;
  logic        MEIE;
  logic        MTIE;
  // Pipeline decode / control
  logic        wfi_dec;
  logic        mret_dec;
  logic        stall;
  logic [31:0] mtvec_PC;
  logic [31:0] mepc_PC;
  // Results towards CSR file and fetch
  logic        SENSOR_CTRL_interrupt;
  logic        WDT_interrupt;
  logic        interrupt_taken;
  logic        MRET;
  logic        WFI_mode;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        pipe_flush;

  // Core side: drives sources/decode, consumes redirect and status
  modport master (
    output sensor_irq_raw, wdt_irq_raw, MIE, MEIE, MTIE,
    output wfi_dec, mret_dec, stall, mtvec_PC, mepc_PC,
    input  SENSOR_CTRL_interrupt, WDT_interrupt, interrupt_taken, MRET,
    input  WFI_mode, pc_redirect, pc_target, pipe_flush
  );

  // Sequencer side
  modport slave (
    input  sensor_irq_raw, wdt_irq_raw, MIE, MEIE, MTIE,
    input  wfi_dec, mret_dec, stall, mtvec_PC, mepc_PC,
    output SENSOR_CTRL_interrupt, WDT_interrupt, interrupt_taken, MRET,
    output WFI_mode, pc_redirect, pc_target, pipe_flush
  );
endinterface

`default_nettype wire

// File: rtl/interrupt_ctrl.sv
//------------------------------------------------------------------------------
// Module      : interrupt_ctrl
// Description : Interrupt and trap sequencer. Synchronizes the sensor and
//               watchdog interrupt lines, qualifies them with MIE/MEIE/MTIE and
//               sequences WFI sleep, trap entry and MRET return. All control
//               outputs are registered alongside the state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module interrupt_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  interrupt_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SLEEP   = 3'd1,
    ST_TRAP    = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RET     = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sensor_sync;
  logic [SYNC_STAGES-1:0] r_wdt_sync;
  logic                   w_sensor_lvl;
  logic                   w_wdt_lvl;
  logic                   w_pend;
  logic                   w_take;
  state_t                 r_state;
  state_t                 w_next;
  logic                   r_taken;
  logic                   r_mret;
  logic                   r_wfi;
  logic                   r_redirect;
  logic                   r_flush;
  logic [31:0]            r_target;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      // Single flop per raw line
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sensor_sync <= '0;
          r_wdt_sync    <= '0;
        end else begin
          r_sensor_sync <= bus.sensor_irq_raw;
          r_wdt_sync    <= bus.wdt_irq_raw;
        end
      end
    end else begin : g_sync_chain
      // Shift raw lines through a SYNC_STAGES-deep flop chain
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sensor_sync <= '0;
          r_wdt_sync    <= '0;
        end else begin
          r_sensor_sync <= {r_sensor_sync[SYNC_STAGES-2:0], bus.sensor_irq_raw};
          r_wdt_sync    <= {r_wdt_sync[SYNC_STAGES-2:0], bus.wdt_irq_raw};
        end
      end
    end
  endgenerate

  assign w_sensor_lvl = r_sensor_sync[SYNC_STAGES-1];
  assign w_wdt_lvl    = r_wdt_sync[SYNC_STAGES-1];

  // Enabled pending interrupt, and whether it may be taken this cycle
  assign w_pend = (w_sensor_lvl & bus.MEIE) | (w_wdt_lvl & bus.MTIE);
  assign w_take = w_pend & bus.MIE & ~bus.stall;

  // Next-state decision; take wins over WFI, MRET only counts in HANDLER
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_take)
          w_next = ST_TRAP;
        else if (bus.wfi_dec && !bus.stall && !w_pend)
          w_next = ST_SLEEP;
      end
      ST_SLEEP: begin
        // Wake-up ignores stall; with MIE clear it resumes without a trap
        if (w_take)
          w_next = ST_TRAP;
        else if (w_pend)
          w_next = ST_RUN;
      end
      ST_TRAP:    w_next = ST_HANDLER;
      ST_HANDLER: begin
        // No nesting: pending interrupts are not looked at here
        if (bus.mret_dec && !bus.stall)
          w_next = ST_RET;
      end
      ST_RET:     w_next = ST_RUN;
      default:    w_next = ST_RUN;
    endcase
  end

  // State register plus outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_taken    <= 1'b0;
      r_mret     <= 1'b0;
      r_wfi      <= 1'b0;
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      r_target   <= 32'd0;
    end else begin
      r_state    <= w_next;
      r_taken    <= (w_next == ST_TRAP);
      r_mret     <= (w_next == ST_RET);
      r_wfi      <= (w_next == ST_SLEEP);
      r_redirect <= (w_next == ST_TRAP) || (w_next == ST_RET);
      r_flush    <= (w_next == ST_TRAP) || (w_next == ST_RET);
      if (w_next == ST_TRAP)
        r_target <= bus.mtvec_PC;
      else if (w_next == ST_RET)
        r_target <= bus.mepc_PC;
      else
        r_target <= 32'd0;
    end
  end

  assign bus.SENSOR_CTRL_interrupt = w_sensor_lvl;
  assign bus.WDT_interrupt         = w_wdt_lvl;
  assign bus.interrupt_taken       = r_taken;
  assign bus.MRET                  = r_mret;
  assign bus.WFI_mode              = r_wfi;
  assign bus.pc_redirect           = r_redirect;
  assign bus.pc_target             = r_target;
  assign bus.pipe_flush            = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_interrupt_ctrl
// Description : Self-checking bench for interrupt_ctrl. Directed scenarios
//               followed by randomized traffic, every cycle compared against
//               a behavioural model of the sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_ctrl;

  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  interrupt_ctrl_if bus ();

  interrupt_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: raw-history queues and semantic flags
  bit          sq[$];
  bit          wq[$];
  bit          m_sens, m_wdt;
  bit          m_sleeping, m_trap, m_ret, m_handler;
  logic [31:0] m_tgt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq = {};
    wq = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sq.push_back(1'b0);
      wq.push_back(1'b0);
    end
    m_sens = 0; m_wdt = 0;
    m_sleeping = 0; m_trap = 0; m_ret = 0; m_handler = 0;
    m_tgt = 32'd0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge values
  task automatic model_edge();
    bit pend, take;
    pend = (m_sens & bus.MEIE) | (m_wdt & bus.MTIE);
    take = pend & bus.MIE & !bus.stall;
    if (rst) begin
      model_reset();
    end else begin
      if (m_trap) begin
        m_trap = 0; m_handler = 1; m_tgt = 0;
      end else if (m_ret) begin
        m_ret = 0; m_tgt = 0;
      end else if (m_handler) begin
        if (bus.mret_dec && !bus.stall) begin
          m_handler = 0; m_ret = 1; m_tgt = bus.mepc_PC;
        end
      end else if (take) begin
        m_sleeping = 0; m_trap = 1; m_tgt = bus.mtvec_PC;
      end else if (m_sleeping) begin
        if (pend) m_sleeping = 0;
      end else if (bus.wfi_dec && !bus.stall && !pend) begin
        m_sleeping = 1;
      end
      sq.push_back(bus.sensor_irq_raw); void'(sq.pop_front());
      wq.push_back(bus.wdt_irq_raw);    void'(wq.pop_front());
      m_sens = sq[0];
      m_wdt  = wq[0];
    end
  endtask

  // Advance one cycle and compare every output against the model
  task automatic step();
    logic [6:0] obs, exp;
    @(posedge clk);
    model_edge();
    #1;
    obs = {bus.interrupt_taken, bus.MRET, bus.WFI_mode, bus.pc_redirect,
           bus.pipe_flush, bus.SENSOR_CTRL_interrupt, bus.WDT_interrupt};
    exp = {m_trap, m_ret, m_sleeping, m_trap | m_ret, m_trap | m_ret, m_sens, m_wdt};
    check_val("flags", {25'd0, obs}, {25'd0, exp});
    check_val("pc_target", bus.pc_target, m_tgt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_wfi();
    bus.wfi_dec = 1; step(); bus.wfi_dec = 0;
  endtask

  task automatic pulse_mret();
    bus.mret_dec = 1; step(); bus.mret_dec = 0;
  endtask

  initial begin
    int n;
    int hold;
    rst = 1;
    bus.sensor_irq_raw = 0; bus.wdt_irq_raw = 0;
    bus.MIE = 0; bus.MEIE = 0; bus.MTIE = 0;
    bus.wfi_dec = 0; bus.mret_dec = 0; bus.stall = 0;
    bus.mtvec_PC = 32'h0001_0000; bus.mepc_PC = 32'h0000_0124;
    model_reset();
    steps(3);
    check_val("rst_taken", {31'd0, bus.interrupt_taken}, 32'd0);
    check_val("rst_target", bus.pc_target, 32'd0);
    rst = 0;

    // Trap entry latency and vector
    bus.MIE = 1; bus.MEIE = 1;
    steps(6);
    bus.sensor_irq_raw = 1;
    n = 0;
    do begin step(); n++; end while (!bus.SENSOR_CTRL_interrupt && n < 10);
    check_val("sync_lat", n, SYNC_STAGES);
    do begin step(); n++; end while (!bus.interrupt_taken && n < 10);
    check_val("taken_lat", n, SYNC_STAGES + 1);
    check_val("trap_vec", bus.pc_target, 32'h0001_0000);
    steps(2);
    // Drop irq in handler, let it drain, then return
    bus.sensor_irq_raw = 0;
    steps(SYNC_STAGES + 2);
    pulse_mret();
    check_val("mret_pulse", {31'd0, bus.MRET}, 32'd1);
    check_val("mret_pc", bus.pc_target, 32'h0000_0124);
    steps(3);

    // WFI sleep held, then watchdog trap wakes it
    bus.MEIE = 0; bus.MTIE = 1;
    pulse_wfi();
    hold = 0;
    for (int i = 0; i < 50; i++) begin step(); if (bus.WFI_mode) hold++; end
    check_val("wfi_hold", hold, 50);
    bus.wdt_irq_raw = 1;
    n = 0;
    do begin step(); n++; end while (!bus.interrupt_taken && n < 10);
    check_val("wfi_trap_wake", {31'd0, bus.WFI_mode}, 32'd0);
    // No nesting with MIE set and wdt still pending
    steps(10);
    bus.wdt_irq_raw = 0;
    steps(SYNC_STAGES + 1);
    // MRET under stall must not act
    bus.stall = 1; bus.mret_dec = 1;
    steps(3);
    bus.stall = 0;
    step();
    bus.mret_dec = 0;
    steps(3);

    // WFI with MIE clear: sensor wakes without trap
    bus.MIE = 0; bus.MEIE = 1;
    pulse_wfi();
    steps(5);
    bus.sensor_irq_raw = 1;
    steps(6);
    bus.sensor_irq_raw = 0;
    steps(SYNC_STAGES + 2);

    // Stall gating of trap entry
    bus.MIE = 1; bus.stall = 1; bus.sensor_irq_raw = 1;
    steps(SYNC_STAGES + 5);
    bus.stall = 0;
    steps(3);
    bus.sensor_irq_raw = 0;
    steps(SYNC_STAGES + 1);
    pulse_mret();
    steps(3);

    // Reset while sleeping
    pulse_wfi();
    steps(3);
    rst = 1; step(); rst = 0;
    check_val("rst_sleep", {31'd0, bus.WFI_mode}, 32'd0);
    steps(2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) bus.sensor_irq_raw = ~bus.sensor_irq_raw;
      if ($urandom_range(0, 19) == 0) bus.wdt_irq_raw = ~bus.wdt_irq_raw;
      if ($urandom_range(0, 29) == 0) bus.MIE  = ~bus.MIE;
      if ($urandom_range(0, 29) == 0) bus.MEIE = ~bus.MEIE;
      if ($urandom_range(0, 29) == 0) bus.MTIE = ~bus.MTIE;
      bus.wfi_dec  = ($urandom_range(0, 7) == 0);
      bus.mret_dec = ($urandom_range(0, 5) == 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.mtvec_PC = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) bus.mepc_PC  = $urandom & 32'hFFFF_FFFC;
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
